// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode command sequencer: FSM state encoding,
// SD command numbers, R1 bit positions and CRC7 constants.
// The optional serial CRC7 path is selected with the SD_CMD_CRC_EN macro.
package sd_pkg;

    // Sequencer states. Each byte phase has an ISSUE cycle (spi_start) and a
    // WAIT state that holds until the SPI engine reports spi_done.
    typedef enum logic [3:0] {
        StIdle,
        StGapIssue,
        StGapWait,
        StFrameIssue,
        StFrameWait,
        StPollIssue,
        StPollWait,
        StTrailIssue,
        StTrailWait,
        StDone
    } sd_state_e;

    // SD command numbers issued through this block by the card controller.
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    // R1 response bit positions. Bit 7 is always 0 in a valid R1.
    localparam int unsigned R1_IDLE          = 0;
    localparam int unsigned R1_ERASE_RESET   = 1;
    localparam int unsigned R1_ILLEGAL_CMD   = 2;
    localparam int unsigned R1_CRC_ERR       = 3;
    localparam int unsigned R1_ERASE_SEQ_ERR = 4;
    localparam int unsigned R1_ADDR_ERR      = 5;
    localparam int unsigned R1_PARAM_ERR     = 6;
    localparam int unsigned R1_START         = 7;

    // CRC7 generator x^7 + x^3 + 1 without the implicit x^7 term.
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Precomputed CRC bytes for the two commands that are checked in SPI mode.
    localparam logic [7:0] CRC_BYTE_CMD0    = 8'h95;
    localparam logic [7:0] CRC_BYTE_CMD8    = 8'h87;
    localparam logic [7:0] CRC_BYTE_DEFAULT = 8'h01;

    // Idle-high filler byte used for gaps, polling and trailer reads.
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Last byte index of the command frame and of the R3/R7 trailer.
    localparam logic [7:0] FRAME_LAST = 8'd5;
    localparam logic [7:0] TRAIL_LAST = 8'd3;

    // Advance a CRC7 register over one byte, MSB first.
    function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ CRC7_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 (x^7 + x^3 + 1) over the SD command frame.
// Only built when SD_CMD_CRC_EN is defined; otherwise the sequencer uses
// fixed CRC bytes and this module does not exist.
`ifdef SD_CMD_CRC_EN
module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] data,
    output logic [6:0] crc
);
    import sd_pkg::*;

    logic [6:0] crc_q;

    // CRC register: cleared per command, advanced one byte per valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 7'd0;
        end else if (clear) begin
            crc_q <= 7'd0;
        end else if (byte_valid) begin
            crc_q <= crc7_update(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule
`endif

// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode command sequencer. Frames one 6-byte command over a byte-wide
// SPI engine, polls for R1 and optionally reads a 4-byte R3/R7 trailer.
// Define SD_CMD_CRC_EN to compute CRC7 with sd_crc7; otherwise fixed CRC
// bytes are used (only CMD0 and CMD8 are CRC-checked by cards in SPI mode).
module sd_cmd_sequencer #(
    parameter int unsigned POLL_MAX  = 8,
    parameter int unsigned GAP_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_long_resp,
    input  logic        cmd_hold_cs,
    output logic        done,
    output logic [7:0]  r1,
    output logic [31:0] resp_ext,
    output logic        timeout,
    output logic        cs_n,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    input  logic [7:0]  spi_rx_byte,
    input  logic        spi_done
);
    import sd_pkg::*;

    localparam logic [7:0] PollLast = 8'(POLL_MAX - 1);
    // Unused when GAP_BYTES is 0; the gap states are then never entered.
    localparam logic [7:0] GapLast  = 8'(GAP_BYTES - 1);

    sd_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic        long_q;
    logic        hold_q;
    logic [7:0]  r1_q;
    logic [31:0] resp_q;
    logic        timeout_q;
    logic        cs_n_q;

    logic        accept;
    logic [7:0]  crc_byte;
    logic [7:0]  frame_byte;

    assign accept = (state_q == StIdle) && cmd_valid;

`ifdef SD_CMD_CRC_EN
    logic [6:0] crc_val;
    logic       crc_byte_valid;

    // Feed frame bytes 0..4 into the CRC as they are issued, so byte 5 is ready.
    assign crc_byte_valid = (state_q == StFrameIssue) && (cnt_q < FRAME_LAST);

    sd_crc7 u_crc7 (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .byte_valid (crc_byte_valid),
        .data       (frame_byte),
        .crc        (crc_val)
    );

    assign crc_byte = {crc_val, 1'b1};
`else
    // Fixed CRC byte: only CMD0 and CMD8 need a correct CRC in SPI mode.
    always_comb begin
        crc_byte = CRC_BYTE_DEFAULT;
        if (idx_q == CMD0) begin
            crc_byte = CRC_BYTE_CMD0;
        end else if (idx_q == CMD8) begin
            crc_byte = CRC_BYTE_CMD8;
        end
    end
`endif

    // Select the command frame byte addressed by the byte counter.
    always_comb begin
        frame_byte = FILL_BYTE;
        unique case (cnt_q[2:0])
            3'd0:    frame_byte = {2'b01, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            3'd5:    frame_byte = crc_byte;
            default: frame_byte = FILL_BYTE;
        endcase
    end

    // State register and per-phase byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: issue a byte, wait for spi_done, then advance the phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cnt_d   = 8'd0;
                    state_d = (GAP_BYTES == 0) ? StFrameIssue : StGapIssue;
                end
            end
            StGapIssue: state_d = StGapWait;
            StGapWait: begin
                if (spi_done) begin
                    if (cnt_q == GapLast) begin
                        cnt_d   = 8'd0;
                        state_d = StFrameIssue;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StGapIssue;
                    end
                end
            end
            StFrameIssue: state_d = StFrameWait;
            StFrameWait: begin
                if (spi_done) begin
                    if (cnt_q == FRAME_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = StPollIssue;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StFrameIssue;
                    end
                end
            end
            StPollIssue: state_d = StPollWait;
            StPollWait: begin
                if (spi_done) begin
                    if (!spi_rx_byte[R1_START]) begin
                        cnt_d   = 8'd0;
                        state_d = long_q ? StTrailIssue : StDone;
                    end else if (cnt_q == PollLast) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StPollIssue;
                    end
                end
            end
            StTrailIssue: state_d = StTrailWait;
            StTrailWait: begin
                if (spi_done) begin
                    if (cnt_q == TRAIL_LAST) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StTrailIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch, response capture and chip-select ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 6'd0;
            arg_q     <= 32'd0;
            long_q    <= 1'b0;
            hold_q    <= 1'b0;
            r1_q      <= FILL_BYTE;
            resp_q    <= 32'd0;
            timeout_q <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            if (accept) begin
                idx_q     <= cmd_index;
                arg_q     <= cmd_arg;
                long_q    <= cmd_long_resp;
                hold_q    <= cmd_hold_cs;
                resp_q    <= 32'd0;
                timeout_q <= 1'b0;
                cs_n_q    <= 1'b0;
            end
            if ((state_q == StPollWait) && spi_done) begin
                if (!spi_rx_byte[R1_START]) begin
                    r1_q <= spi_rx_byte;
                end else if (cnt_q == PollLast) begin
                    r1_q      <= FILL_BYTE;
                    timeout_q <= 1'b1;
                end
            end
            if ((state_q == StTrailWait) && spi_done) begin
                resp_q <= {resp_q[23:0], spi_rx_byte};
            end
            // A held chip select survives until a non-holding command completes.
            if ((state_q == StDone) && !hold_q) begin
                cs_n_q <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        done        = (state_q == StDone);
        spi_start   = 1'b0;
        spi_tx_byte = FILL_BYTE;
        unique case (state_q)
            StGapIssue, StPollIssue, StTrailIssue: spi_start = 1'b1;
            StFrameIssue: begin
                spi_start   = 1'b1;
                spi_tx_byte = frame_byte;
            end
            StFrameWait: spi_tx_byte = frame_byte;
            default: ;
        endcase
    end

    assign r1       = r1_q;
    assign resp_ext = resp_q;
    assign timeout  = timeout_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: directed table, reset-abort
// sequence and randomized commands against a behavioural transaction model.
module tb_sd_cmd_sequencer;

    localparam int POLL_MAX  = 8;
    localparam int GAP_BYTES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_long_resp;
    logic        cmd_hold_cs;
    logic        done;
    logic [7:0]  r1;
    logic [31:0] resp_ext;
    logic        timeout;
    logic        cs_n;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic [7:0]  spi_rx_byte;
    logic        spi_done;

    sd_cmd_sequencer #(
        .POLL_MAX  (POLL_MAX),
        .GAP_BYTES (GAP_BYTES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_index     (cmd_index),
        .cmd_arg       (cmd_arg),
        .cmd_long_resp (cmd_long_resp),
        .cmd_hold_cs   (cmd_hold_cs),
        .done          (done),
        .r1            (r1),
        .resp_ext      (resp_ext),
        .timeout       (timeout),
        .cs_n          (cs_n),
        .spi_start     (spi_start),
        .spi_tx_byte   (spi_tx_byte),
        .spi_rx_byte   (spi_rx_byte),
        .spi_done      (spi_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 60) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SPI engine model ----------------
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    bit         busy;
    int         lat;
    int         last_done_cyc;
    int         proto_err = 0;

    initial begin
        spi_done    = 1'b0;
        spi_rx_byte = 8'hFF;
        busy        = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                busy     = 1'b0;
                spi_done = 1'b0;
            end else begin
                #1;
                spi_done = 1'b0;
                if (busy) begin
                    if (spi_start) proto_err++;
                    if (lat == 0) begin
                        spi_done = 1'b1;
                        // Gap and frame bytes echo junk that must be ignored.
                        if (tx_log.size() <= GAP_BYTES + 6) spi_rx_byte = 8'($urandom);
                        else if (rx_q.size() > 0) spi_rx_byte = rx_q.pop_front();
                        else spi_rx_byte = 8'hFF;
                        busy          = 1'b0;
                        last_done_cyc = cyc;
                    end else begin
                        lat--;
                    end
                end else if (spi_start) begin
                    tx_log.push_back(spi_tx_byte);
                    busy = 1'b1;
                    lat  = $urandom_range(0, 2);
                end
            end
        end
    end

    // ---------------- Reference model ----------------
    // CRC7 as the remainder of (message * x^7) divided by x^7 + x^3 + 1.
    function automatic logic [7:0] ref_crc_byte(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CMD_CRC_EN
        logic [46:0] m;
        m = {2'b01, idx, arg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (m[i]) m = m ^ (47'h89 << (i - 7));
        end
        return {m[6:0], 1'b1};
`else
        if (idx == 6'd0) return 8'h95;
        if (idx == 6'd8) return 8'h87;
        return 8'h01;
`endif
    endfunction

    // Run one command; rx_q must hold the card's bytes after the frame.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                           input logic hold, input bit keep_valid,
                           output logic [7:0] got_r1, output logic got_to,
                           output logic [31:0] got_ext);
        logic [7:0]  resp[$];
        logic [7:0]  exp_tx[$];
        logic [7:0]  exp_r1;
        logic        exp_to;
        logic [31:0] exp_ext;
        int          k;
        int          t;
        int          ready_busy;
        resp    = rx_q;
        tx_log  = {};
        exp_tx  = {};
        exp_ext = 32'd0;
        k = -1;
        for (int i = 0; i < resp.size(); i++) begin
            if (!resp[i][7]) begin
                k = i;
                break;
            end
        end
        for (int i = 0; i < GAP_BYTES; i++) exp_tx.push_back(8'hFF);
        exp_tx.push_back({2'b01, idx});
        exp_tx.push_back(arg[31:24]);
        exp_tx.push_back(arg[23:16]);
        exp_tx.push_back(arg[15:8]);
        exp_tx.push_back(arg[7:0]);
        exp_tx.push_back(ref_crc_byte(idx, arg));
        if (k < 0 || k >= POLL_MAX) begin
            exp_to = 1'b1;
            exp_r1 = 8'hFF;
            for (int i = 0; i < POLL_MAX; i++) exp_tx.push_back(8'hFF);
        end else begin
            exp_to = 1'b0;
            exp_r1 = resp[k];
            for (int i = 0; i <= k; i++) exp_tx.push_back(8'hFF);
            if (lng) begin
                for (int i = 1; i <= 4; i++) begin
                    exp_ext = {exp_ext[23:0], (k + i < resp.size()) ? resp[k + i] : 8'hFF};
                    exp_tx.push_back(8'hFF);
                end
            end
        end

        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_index     = idx;
        cmd_arg       = arg;
        cmd_long_resp = lng;
        cmd_hold_cs   = hold;
        @(negedge clk);
        check("ready_low_after_accept", cmd_ready, 1'b0);
        check("cs_n_low_after_accept", cs_n, 1'b0);
        if (!keep_valid) cmd_valid = 1'b0;
        t = 0;
        ready_busy = 0;
        while (!done && t < 2000) begin
            if (cmd_ready) ready_busy++;
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        check("done_seen", done, 1'b1);
        got_r1  = r1;
        got_to  = timeout;
        got_ext = resp_ext;
        if (!done) return;
        check("ready_low_while_busy", ready_busy, 0);
        check("r1", r1, exp_r1);
        check("timeout", timeout, exp_to);
        if (lng && !exp_to) check("resp_ext", resp_ext, exp_ext);
        check("cs_n_low_at_done", cs_n, 1'b0);
        check("done_one_after_spi_done", cyc - last_done_cyc, 1);
        check("tx_count", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
            check($sformatf("tx_byte[%0d]", i), tx_log[i], exp_tx[i]);
        end
        check("spi_protocol_errors", proto_err, 0);
        @(negedge clk);
        check("done_single_cycle", done, 1'b0);
        check("ready_after_done", cmd_ready, 1'b1);
        check("cs_n_after_done", cs_n, hold ? 1'b0 : 1'b1);
        rx_q = {};
    endtask

    // ---------------- Directed table ----------------
    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        lng;
        logic        hold;
        int          nresp;
        logic [63:0] resp;   // card bytes after the frame, first in [63:56]
        logic [7:0]  exp_r1;
        logic        exp_to;
        logic [31:0] exp_ext;
        logic        chk_crc;
        logic [7:0]  exp_crc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0]  g_r1;
        logic        g_to;
        logic [31:0] g_ext;
        int          t;
        bit          saw_done;

        vecs[0] = '{6'd0,  32'h0,     1'b0, 1'b0, 3, 64'hFFFF01_0000000000, 8'h01, 1'b0, 32'h0,     1'b1, 8'h95};
        vecs[1] = '{6'd8,  32'h1AA,   1'b1, 1'b0, 5, 64'h01000001AA_000000, 8'h01, 1'b0, 32'h1AA,   1'b1, 8'h87};
        vecs[2] = '{6'd55, 32'h0,     1'b1, 1'b0, 0, 64'h0,                 8'hFF, 1'b1, 32'h0,     1'b0, 8'h00};
        vecs[3] = '{6'd17, 32'h0,     1'b0, 1'b1, 2, 64'hFF00_000000000000, 8'h00, 1'b0, 32'h0,     1'b0, 8'h00};
        vecs[4] = '{6'd0,  32'h0,     1'b0, 1'b0, 1, 64'h01_00000000000000, 8'h01, 1'b0, 32'h0,     1'b1, 8'h95};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_index = 6'd0;
        cmd_arg = 32'd0;
        cmd_long_resp = 1'b0;
        cmd_hold_cs = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_done", done, 1'b0);
        check("reset_r1", r1, 8'hFF);
        check("reset_resp_ext", resp_ext, 32'h0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_cs_n", cs_n, 1'b1);
        check("reset_spi_start", spi_start, 1'b0);
        check("reset_spi_tx_byte", spi_tx_byte, 8'hFF);

        for (int v = 0; v < 5; v++) begin
            rx_q = {};
            for (int b = 0; b < vecs[v].nresp; b++) rx_q.push_back(vecs[v].resp[63 - 8 * b -: 8]);
            run_cmd(vecs[v].idx, vecs[v].arg, vecs[v].lng, vecs[v].hold, 1'b0, g_r1, g_to, g_ext);
            check($sformatf("vec%0d_r1", v), g_r1, vecs[v].exp_r1);
            check($sformatf("vec%0d_timeout", v), g_to, vecs[v].exp_to);
            if (vecs[v].lng && !vecs[v].exp_to) check($sformatf("vec%0d_ext", v), g_ext, vecs[v].exp_ext);
            if (vecs[v].chk_crc && tx_log.size() > GAP_BYTES + 5)
                check($sformatf("vec%0d_crc", v), tx_log[GAP_BYTES + 5], vecs[v].exp_crc);
            // Chip select must stay put while idle between commands.
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_cs_n_idle", v), cs_n, vecs[v].hold ? 1'b0 : 1'b1);
        end

        // Reset while frame byte 3 is being issued.
        rx_q = {8'h01};
        tx_log = {};
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_index = 6'd0;
        cmd_arg = 32'd0;
        cmd_long_resp = 1'b0;
        cmd_hold_cs = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!(spi_start && tx_log.size() == GAP_BYTES + 4) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rst_reached_frame3", spi_start && tx_log.size() == GAP_BYTES + 4, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_abort_cs_n", cs_n, 1'b1);
        check("rst_abort_ready", cmd_ready, 1'b1);
        check("rst_abort_spi_start", spi_start, 1'b0);
        check("rst_abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 1'b0);
        rx_q = {8'h01};
        run_cmd(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, g_r1, g_to, g_ext);
        check("post_rst_cmd0_r1", g_r1, 8'h01);

        // Randomized commands; the model inside run_cmd supplies expectations.
        for (int n = 0; n < 60; n++) begin
            int lead;
            rx_q = {};
            lead = $urandom_range(0, 10);
            for (int i = 0; i < lead; i++) rx_q.push_back(8'h80 | 8'($urandom));
            rx_q.push_back(8'($urandom) & 8'h7F);
            for (int i = 0; i < 4; i++) rx_q.push_back(8'($urandom));
            run_cmd(6'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                    g_r1, g_to, g_ext);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Sequences one SD SPI-mode command transaction over the existing byte-wide SPI transfer engine (spi_controller).
- Frames a 6-byte command (index, 32-bit argument, CRC7 byte), drives chip select, polls for the R1 response and optionally collects a 4-byte R3/R7 trailer.
- Sits between the SD card controller's init/read/write FSM and the SPI engine; that FSM issues CMD0, CMD8, ACMD41, CMD17, CMD24 etc. through this block.

Parameters:
- POLL_MAX, 8: maximum response bytes polled before timeout (1..255).
- GAP_BYTES, 1: 0xFF filler bytes sent with cs_n low before the command frame (0..15).

Ports:
- clk  input  1  master clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; transfer on cmd_valid & cmd_ready.
- cmd_index  input  6  SD command number.
- cmd_arg  input  32  command argument.
- cmd_long_resp  input  1  collect 4 trailer bytes after R1 (R3/R7).
- cmd_hold_cs  input  1  keep cs_n low after completion (data phase follows).
- done  output  1  one-cycle pulse when the transaction ends.
- r1  output  8  R1 response byte; valid from done onward.
- resp_ext  output  32  trailer bytes, first received in [31:24].
- timeout  output  1  set with done if no R1 seen; cleared on next accept.
- cs_n  output  1  SD chip select, active low.
- spi_start  output  1  one-cycle pulse to launch one byte transfer.
- spi_tx_byte  output  8  byte to transmit; stable from spi_start until spi_done.
- spi_rx_byte  input  8  received byte; valid in the spi_done cycle.
- spi_done  input  1  one-cycle pulse, byte transfer complete.

Behaviour:
- Reset values (asynchronous): state IDLE, cmd_ready=1, done=0, r1=8'hFF, resp_ext=0, timeout=0, cs_n=1, spi_start=0, spi_tx_byte=8'hFF.
- Accept: in IDLE with cmd_valid=1, latch cmd_index/arg/long_resp/hold_cs, clear timeout, drive cs_n=0, go to GAP (or FRAME if GAP_BYTES=0). cmd_ready falls the next cycle.
- Byte issue rule: every byte uses an ISSUE cycle (spi_start=1, tx loaded) followed by a WAIT state until spi_done. The next spi_start comes no earlier than the cycle after spi_done. spi_done outside WAIT is ignored.
- GAP: send GAP_BYTES × 8'hFF.
- FRAME: bytes 0..5 are {2'b01, cmd_index}, then arg[31:24], arg[23:16], arg[15:8], arg[7:0], then {crc7, 1'b1}. CRC7 uses polynomial x^7+x^3+1, initial 0, over bytes 0..4.
- POLL: transmit 8'hFF. The first rx byte with bit7=0 is R1 and is latched into r1; then go to TRAIL if long_resp else DONE. After POLL_MAX bytes with bit7=1: r1=8'hFF, timeout=1, go to DONE (no TRAIL).
- TRAIL: 4 × 8'hFF, shift rx bytes into resp_ext MSB-first.
- DONE: one cycle. done=1. cs_n returns to 1 unless hold_cs was latched. Then IDLE.
- With hold_cs latched, cs_n stays 0 through IDLE until the next accepted command with cmd_hold_cs=0 completes.
- Reset mid-transaction: immediate abort, cs_n=1, no done pulse. An in-flight SPI byte is abandoned; the SPI engine is reset from the same rst.
- cmd_valid while busy: ignored, no queuing.

Optional Feature:
- Macro: SD_CMD_CRC_EN.
- Defined: CRC7 is computed serially by the CRC sub-module, one byte per FRAME byte.
- Undefined: no CRC logic. Byte 5 = 8'h95 when cmd_index=0, 8'h87 when cmd_index=8, otherwise 8'h01 (SPI mode ignores CRC after CMD8).

Decomposition:
- Shared package sd_pkg: state encoding constants, command index constants (CMD0, CMD8, CMD17, CMD24, CMD55, ACMD41), R1 bit positions, CRC7 polynomial constant 7'h09, fixed CRC bytes 8'h95 and 8'h87.
- Sub-module sd_crc7: byte-serial CRC7 with clear, byte_valid and data inputs; exists only under SD_CMD_CRC_EN.

Test Plan:
- CMD0, arg 0, SPI model returns FF,FF,01: tx sequence FF, 40,00,00,00,00,95, FF,FF,FF; r1=01; timeout=0; done one cycle after third poll spi_done; cs_n=1 after done.
- CMD8, arg 0x000001AA, long_resp=1, model returns 01 then 00,00,01,AA: frame 48,00,00,01,AA,87; r1=01; resp_ext=0x000001AA.
- Timeout: model returns FF always, POLL_MAX=8: exactly 8 poll bytes; r1=FF; timeout=1; no trailer bytes; cs_n=1.
- hold_cs=1 on CMD17 arg 0: cs_n stays 0 after done and through IDLE. A following CMD with hold_cs=0 releases cs_n only after its done.
- rst asserted during FRAME byte 3: cs_n=1, cmd_ready=1, spi_start=0 immediately; no done; the next CMD0 completes normally.
- Run the CMD0 and CMD8 cases with and without SD_CMD_CRC_EN: identical CRC bytes (95, 87) in both builds.
